// File: rtl/pc_pkg.sv
// Shared definitions for the next-PC unit: flow-op encodings and FSM state type.
package pc_pkg;

   localparam logic [2:0] BR_NONE = 3'd0;
   localparam logic [2:0] BR_J    = 3'd1;
   localparam logic [2:0] BR_BEQ  = 3'd2;
   localparam logic [2:0] BR_BNE  = 3'd3;
   localparam logic [2:0] BR_CALL = 3'd4;
   localparam logic [2:0] BR_RET  = 3'd5;
   localparam logic [2:0] BR_HALT = 3'd6;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push while full silently overwrites the oldest entry.
module ras_stack #(
   parameter int RAS_DEPTH = 4,
   parameter int PC_W      = 32
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] push_data,
   output logic [PC_W-1:0] top,
   output logic            empty
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PC_W-1:0]  mem [RAS_DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [CNT_W-1:0] count;
   logic             full;

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(RAS_DEPTH));
   assign top   = mem[ptr - PTR_W'(1)];

   // ptr is the next write slot; when full it points at the oldest entry
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ptr   <= '0;
         count <= '0;
      end else if (push) begin
         ptr <= ptr + PTR_W'(1);
         if (!full)
            count <= count + CNT_W'(1);
      end else if (pop && !empty) begin
         ptr   <= ptr - PTR_W'(1);
         count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (push)
         mem[ptr] <= push_data;
   end

endmodule

// File: rtl/pc_unit.sv
// Next-PC and flow-control unit: PC register, sequential/target adders, return stack,
// busywait stall, halt and retired-instruction counter.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | executing; one op per cycle unless BUSYWAIT holds everything
//   ST_HALT | PC, stack and counter frozen; left only through RESET
module pc_unit
   import pc_pkg::*;
#(
   parameter int              PC_W      = 32,
   parameter int              OFF_W     = 8,
   parameter int              STEP_LG2  = 2,
   parameter int              RAS_DEPTH = 4,
   parameter int              CNT_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC  = '0
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [2:0]       BR_OP,
   input  logic [OFF_W-1:0] OFFSET,
   input  logic             ZERO,
   input  logic             BUSYWAIT,
   output logic [PC_W-1:0]  PC,
   output logic             HALTED,
   output logic             RAS_ERR,
   output logic [CNT_W-1:0] RETIRED
);

   localparam logic [PC_W-1:0] STEP = PC_W'(1) << STEP_LG2;

   state_t          state, state_nxt;
   logic [PC_W-1:0] seq, tgt, off_ext, pc_nxt, ras_top;
   logic            push, pop, ras_empty, err_set, retire;

   assign off_ext = {{(PC_W-OFF_W){OFFSET[OFF_W-1]}}, OFFSET};
   assign seq     = PC + STEP;
   assign tgt     = seq + (off_ext << STEP_LG2);
   assign HALTED  = (state == ST_HALT);

   ras_stack #(
      .RAS_DEPTH (RAS_DEPTH),
      .PC_W      (PC_W)
   ) u_ras (
      .CLK       (CLK),
      .RESET     (RESET),
      .push      (push),
      .pop       (pop),
      .push_data (seq),
      .top       (ras_top),
      .empty     (ras_empty)
   );

   always_comb begin
      state_nxt = state;
      pc_nxt    = PC;
      push      = 1'b0;
      pop       = 1'b0;
      err_set   = 1'b0;
      retire    = 1'b0;
      if (state == ST_RUN && !BUSYWAIT) begin
         retire = 1'b1;
         pc_nxt = seq;
         case (BR_OP)
            BR_J:    pc_nxt = tgt;
            BR_BEQ:  if (ZERO)  pc_nxt = tgt;
            BR_BNE:  if (!ZERO) pc_nxt = tgt;
            BR_CALL: begin
               push   = 1'b1;
               pc_nxt = tgt;
            end
            BR_RET: begin
               if (!ras_empty) begin
                  pop    = 1'b1;
                  pc_nxt = ras_top;
               end else begin
                  err_set = 1'b1;
               end
            end
            BR_HALT: begin
               pc_nxt    = PC;
               state_nxt = ST_HALT;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state   <= ST_RUN;
         PC      <= RESET_PC;
         RAS_ERR <= 1'b0;
         RETIRED <= '0;
      end else begin
         state <= state_nxt;
         PC    <= pc_nxt;
         if (err_set)
            RAS_ERR <= 1'b1;
         if (retire)
            RETIRED <= RETIRED + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed flow-control scenarios plus random ops checked against
// a queue-based reference model.
module tb_pc_unit;

   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [2:0]  BR_OP = 3'd0;
   logic [7:0]  OFFSET = 8'd0;
   logic        ZERO = 1'b0;
   logic        BUSYWAIT = 1'b0;
   logic [31:0] PC;
   logic        HALTED;
   logic        RAS_ERR;
   logic [31:0] RETIRED;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [31:0] m_pc;
   logic [31:0] m_ret;
   bit          m_halt;
   bit          m_err;
   logic [31:0] m_stack [$];

   pc_unit #(
      .PC_W      (32),
      .OFF_W     (8),
      .STEP_LG2  (2),
      .RAS_DEPTH (DEPTH),
      .CNT_W     (32),
      .RESET_PC  (32'h0)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .BR_OP    (BR_OP),
      .OFFSET   (OFFSET),
      .ZERO     (ZERO),
      .BUSYWAIT (BUSYWAIT),
      .PC       (PC),
      .HALTED   (HALTED),
      .RAS_ERR  (RAS_ERR),
      .RETIRED  (RETIRED)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic [2:0] op, input logic [7:0] off, input bit z, input bit bw);
      logic [31:0] seq, tgt;
      if (m_halt || bw) return;
      seq = m_pc + 32'd4;
      tgt = seq + 32'(int'($signed(off)) * 4);
      m_ret = m_ret + 32'd1;
      case (op)
         3'd1: m_pc = tgt;
         3'd2: m_pc = z ? tgt : seq;
         3'd3: m_pc = z ? seq : tgt;
         3'd4: begin
            m_stack.push_back(seq);
            if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
            m_pc = tgt;
         end
         3'd5: begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin
               m_pc  = seq;
               m_err = 1'b1;
            end
         end
         3'd6: m_halt = 1'b1;
         default: m_pc = seq;
      endcase
   endtask

   task automatic check_all();
      check("pc", PC, m_pc);
      check("retired", RETIRED, m_ret);
      check("halted", 32'(HALTED), 32'(m_halt));
      check("ras_err", 32'(RAS_ERR), 32'(m_err));
   endtask

   task automatic step(input logic [2:0] op, input logic [7:0] off, input bit z, input bit bw);
      BR_OP    = op;
      OFFSET   = off;
      ZERO     = z;
      BUSYWAIT = bw;
      @(posedge CLK);
      #1;
      model_step(op, off, z, bw);
      check_all();
   endtask

   task automatic do_reset();
      #2;
      RESET = 1'b1;
      #1;
      check("rst_pc", PC, 32'h0);
      check("rst_halted", 32'(HALTED), 32'h0);
      m_pc   = 32'h0;
      m_ret  = 32'h0;
      m_halt = 1'b0;
      m_err  = 1'b0;
      m_stack.delete();
      BR_OP    = 3'd0;
      BUSYWAIT = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
      check_all();
   endtask

   initial begin
      logic [31:0] ret_exp [4];
      logic [2:0]  op;
      ret_exp[0] = 32'h54;
      ret_exp[1] = 32'h40;
      ret_exp[2] = 32'h2C;
      ret_exp[3] = 32'h18;

      do_reset();
      check("reset_retired", RETIRED, 32'h0);
      check("reset_err", 32'(RAS_ERR), 32'h0);
      for (int i = 0; i < 3; i++) step(3'd0, 8'h00, 1'b0, 1'b0);
      check("seq_pc", PC, 32'hC);
      check("seq_retired", RETIRED, 32'd3);

      // BEQ / BNE around PC 0x20
      do_reset();
      for (int i = 0; i < 8; i++) step(3'd0, 8'h00, 1'b0, 1'b0);
      step(3'd2, 8'hFE, 1'b1, 1'b0);
      check("beq_taken", PC, 32'h1C);
      step(3'd0, 8'h00, 1'b0, 1'b0);
      step(3'd3, 8'hFE, 1'b1, 1'b0);
      check("bne_not_taken", PC, 32'h24);

      // CALL / RET / RET on empty
      do_reset();
      for (int i = 0; i < 4; i++) step(3'd0, 8'h00, 1'b0, 1'b0);
      step(3'd4, 8'h04, 1'b0, 1'b0);
      check("call_pc", PC, 32'h24);
      step(3'd5, 8'h00, 1'b0, 1'b0);
      check("ret_pc", PC, 32'h14);
      step(3'd5, 8'h00, 1'b0, 1'b0);
      check("ret_empty_pc", PC, 32'h18);
      check("ret_empty_err", 32'(RAS_ERR), 32'h1);
      step(3'd0, 8'h00, 1'b0, 1'b0);
      check("err_sticky", 32'(RAS_ERR), 32'h1);

      // five nested CALLs overflow a 4-deep stack
      do_reset();
      for (int i = 0; i < 5; i++) step(3'd4, 8'h04, 1'b0, 1'b0);
      check("call5_pc", PC, 32'h64);
      for (int i = 0; i < 4; i++) begin
         step(3'd5, 8'h00, 1'b0, 1'b0);
         check($sformatf("nested_ret%0d", i), PC, ret_exp[i]);
      end
      check("nested_no_err", 32'(RAS_ERR), 32'h0);
      step(3'd5, 8'h00, 1'b0, 1'b0);
      check("nested_ret5_err", 32'(RAS_ERR), 32'h1);

      // busywait holds a J
      do_reset();
      for (int i = 0; i < 16; i++) step(3'd0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(3'd1, 8'h10, 1'b0, 1'b1);
         check("bw_pc", PC, 32'h40);
         check("bw_retired", RETIRED, 32'd16);
      end
      step(3'd1, 8'h10, 1'b0, 1'b0);
      check("bw_release_pc", PC, 32'h84);

      // HALT then async reset out of it
      do_reset();
      for (int i = 0; i < 12; i++) step(3'd0, 8'h00, 1'b0, 1'b0);
      step(3'd6, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(3'd1, 8'h10, 1'b0, 1'b0);
      check("halt_pc", PC, 32'h30);
      check("halt_flag", 32'(HALTED), 32'h1);
      check("halt_retired", RETIRED, 32'd13);
      do_reset();

      // random ops; HALT kept rare so most windows keep running
      for (int blk = 0; blk < 8; blk++) begin
         do_reset();
         for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'd6 && $urandom_range(0, 3) != 0) op = 3'd4;
            step(op, 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised next-PC and flow-control block for the single-cycle CPU; replaces the inline PC register, PC+4 adder, offset adder and PC mux in the cpu top level. Supports jump, beq, bne, call/return through a circular return-address stack, a memory busywait stall and a halt state. It counts retired instructions. Sits between the control unit (branch opcode), the ALU (ZERO flag) and instruction memory (PC out, BUSYWAIT in).

## Interface
- PC_W, 32, width of PC and all address arithmetic
- OFF_W, 8, width of the signed branch/jump offset (instruction count)
- STEP_LG2, 2, log2 of instruction size in bytes (4-byte instructions)
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2)
- CNT_W, 32, retired-instruction counter width
- RESET_PC, 0, PC value loaded on reset

- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  asynchronous, active-high reset
- BR_OP  in  3  flow op: 0 NONE, 1 J, 2 BEQ, 3 BNE, 4 CALL, 5 RET, 6 HALT, 7 reserved (treated as NONE)
- OFFSET  in  OFF_W  signed offset in instructions (INSTRUCTION[23:16])
- ZERO  in  1  ALU zero flag for current instruction
- BUSYWAIT  in  1  memory not ready; freezes all state
- PC  out  PC_W  current fetch address
- HALTED  out  1  high while in HALT
- RAS_ERR  out  1  sticky: RET on empty stack
- RETIRED  out  CNT_W  instructions completed since reset

## Operation
- FSM states RUN, HALT. BUSYWAIT is a qualifier in RUN, not a state: while BUSYWAIT=1 nothing changes (PC, stack, pointer, counter, FSM).
- seq = PC + (1 << STEP_LG2); tgt = seq + (sext(OFFSET) << STEP_LG2); all arithmetic modulo 2^PC_W, wrap-around silent.
- RUN, BUSYWAIT=0, at posedge:
  - NONE/reserved: PC←seq.
  - J: PC←tgt.
  - BEQ: PC←tgt if ZERO=1 else seq. BNE: PC←tgt if ZERO=0 else seq.
  - CALL: push seq; PC←tgt. Full stack: oldest entry overwritten (circular), count saturates at RAS_DEPTH.
  - RET: stack non-empty: pop, PC←popped value. Empty: PC←seq, RAS_ERR←1.
  - HALT: PC unchanged, FSM→HALT.
  - RETIRED increments by 1 (wraps at 2^CNT_W) for every op including HALT.
- HALT: PC, stack, RETIRED frozen; inputs ignored; leaves only by RESET.
- HALTED = (state==HALT), combinational from state.
- ZERO and OFFSET are sampled only when BR_OP needs them.

## Timing
- Reset (async assert, deassert synchronous to CLK by the system): PC=RESET_PC, state RUN, stack empty (count 0, pointer 0), RAS_ERR=0, RETIRED=0, HALTED=0. Entries need no clear.
- RESET mid-operation (during stall, HALT or with a CALL pending) aborts immediately; no push completes.
- PC is a register: the new value is visible one clock after the op is presented; one-cycle latency, no bubbles. Ops are single-cycle; no zero-delay loops; no #delays in RTL.
- BUSYWAIT sampled at the same edge as BR_OP; the op is held by the fetch path and re-executed when BUSYWAIT drops.
- CALL while full and RET in the same design cycle cannot occur (one op per cycle).

## Structure
- Package pc_pkg: BR_OP encoding constants, FSM state typedef.
- Sub-module ras_stack (parameters RAS_DEPTH, PC_W): circular buffer with push/pop, count, empty/full flags; pc_unit owns FSM, adders, counter.

## Test plan
- Reset then 3 NONE cycles -> PC 0,4,8,12; RETIRED=3.
- PC=0x20, BEQ OFFSET=0xFE ZERO=1 -> PC=0x1C; BNE same with ZERO=1 -> PC=0x24.
- CALL OFFSET=4 at PC=0x10 -> PC=0x24; RET -> PC=0x14; second RET (empty) -> PC=0x18, RAS_ERR=1 sticky until reset.
- Five nested CALLs with RAS_DEPTH=4, then four RETs -> return addresses of calls 5,4,3,2 in order; fifth RET sets RAS_ERR.
- BUSYWAIT=1 for 3 cycles during J OFFSET=0x10 at PC=0x40 -> PC stays 0x40, RETIRED frozen; after release PC=0x84.
- HALT at PC=0x30 -> PC stays 0x30, HALTED=1 for 10 cycles despite J ops; async RESET mid-cycle -> PC=0 immediately, HALTED=0.
